uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Serial transmit end of the DataPath debug UART; the counterpart of the rx path that the host drives.
//  Accepts bytes from the debug/dump logic into a small FIFO and serialises each one on tx.
//  Frame format is 8N1 by default: start bit, DBIT data bits LSB-first, then stop bits. An internal baud-tick generator paces the bits.
// PARAMETERS
//  DBIT     8    data bits per frame
//  SB_TICK  16   stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//  DVSR     651  clk cycles per oversample tick (100 MHz / (9600*16)); minimum value 2
//  FIFO_AW  2    FIFO address width; depth = 2**FIFO_AW = 4 bytes
// PORTS
//  clk           in   1     system clock; all logic rises on posedge clk
//  reset         in   1     asynchronous, active-low reset (0 = reset asserted)
//  wr_en         in   1     push wr_data into the FIFO this cycle
//  wr_data       in   DBIT  byte to transmit
//  full          out  1     FIFO full; a push while full is ignored
//  tx            out  1     serial line; idle level is 1
//  tx_busy       out  1     high while a frame is on the line or the FIFO is non-empty
//  tx_done_tick  out  1     1-cycle pulse in the last cycle of each stop bit
// BEHAVIOUR
//  Reset (async, on reset==0): tx=1, full=0, tx_busy=0, tx_done_tick=0; FIFO emptied; FSM=IDLE; tick counter=0.
//  Baud tick: counter runs 0..DVSR-1 continuously; s_tick=1 when the count equals DVSR-1. s_tick is free-running, not aligned to the frame start.
//  FIFO: synchronous, first-word fall-through. A push when full is dropped; full does not change.
//   A push and a pop in the same cycle when not full is legal, and the count does not change.
//   A push and a pop in the same cycle when full: the pop happens first, so the push is accepted.
//   The pointers wrap modulo the depth.
//  FSM states: IDLE, START, DATA, STOP. Counters: n_ticks (0..15, or 0..SB_TICK-1 in STOP) and n_bits (0..DBIT-1).
//   IDLE:  tx=1. If the FIFO is non-empty, pop the head into shift register b, clear n_ticks, go to START.
//          The pop takes exactly 1 clk cycle.
//   START: tx=0. On each s_tick increment n_ticks; on the s_tick where n_ticks==15, clear n_ticks and n_bits and go to DATA.
//   DATA:  tx=b[0]. On the s_tick where n_ticks==15, shift b right by one and advance n_bits.
//          After bit DBIT-1, go to STOP.
//   STOP:  tx=1. On the s_tick where n_ticks==SB_TICK-1, pulse tx_done_tick and go to IDLE.
//          Back-to-back bytes: IDLE pops the next byte in the next cycle, so the stop bit is followed directly by the next start bit.
//  tx is driven from a register, so there are no glitches. tx_busy = (state!=IDLE) | ~fifo_empty.
//  Latency: from wr_en with an empty FIFO and an IDLE FSM, tx falls 2 clk cycles later.
//   The start bit itself lasts 16 s_ticks, and the first one may come up to DVSR-1 cycles early.
//  Reset asserted mid-frame: the frame is aborted and tx returns to 1 immediately. No tx_done_tick is emitted.
// STRUCTURE
//  Shared package/header uart_defs.vh: localparams for the FSM state encoding (2 bits), DBIT, DVSR and SB_TICK defaults.
//  Sub-module: uart_fifo (parameters DBIT, FIFO_AW; ports clk, reset, wr, rd, w_data, r_data, empty, full).
//  The baud counter and the FSM stay inline in uart_tx_buffered.
// TESTING
//  Use DVSR=4 in all scenarios (64 clk per bit).
//  1 Reset values: hold reset=0 and toggle clk -> tx=1, full=0, tx_busy=0, tx_done_tick=0.
//  2 Single byte: push 8'hA5 -> tx reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level lasting 64 clk.
//    Exactly one tx_done_tick; tx_busy falls the cycle after it.
//  3 FIFO full: push 5 bytes 8'h01..8'h05 on consecutive cycles.
//    -> The first byte starts transmitting and 4 bytes are held. full rises after the 5th push has been accepted; a 6th push of 8'hFF is dropped.
//    -> Bytes 01..05 appear on tx in order with no idle gap between frames. 5 tx_done_tick pulses.
//  4 Simultaneous push and pop while full: push exactly in the IDLE pop cycle -> the byte is accepted, full stays 1, and no data is lost.
//  5 Reset mid-frame: pull reset low during data bit 3 of 8'h3C.
//    -> tx=1 within the same cycle, the FIFO is empty, and no tx_done_tick. After release, pushing 8'h81 sends a clean frame.
//  6 Wrap-around: stream 10 bytes 8'h10..8'h19, keeping full=0 between pushes -> all 10 bytes are received in order by the bench's rx model.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered debug-UART transmitter.
package uart_tx_buffered_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_DEF    = 651;
    localparam int FIFO_AW_DEF = 2;

    // Start and data bits are always 16 oversample ticks long.
    localparam int OS_TICKS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DBIT    = 8,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DBIT-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;
    logic               do_wr;
    logic               do_rd;

    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
            if (do_wr & ~do_rd)
                count <= count + 1'b1;
            else if (do_rd & ~do_wr)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr] <= w_data;
    end

    assign r_data = mem[rptr];
    assign empty  = (count == '0);
    // count tops out at DEPTH, so its MSB alone flags full
    assign full   = count[FIFO_AW];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter for the DataPath debug UART.
//
//   state | meaning
//   IDLE  | line high; pops the next byte as soon as the FIFO has one
//   START | line low for 16 oversample ticks
//   DATA  | shifts out DBIT bits LSB-first, 16 ticks each
//   STOP  | line high for SB_TICK ticks; done pulse in its final cycle
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF,
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int CW = $clog2(DVSR);
    localparam int TW = $clog2((SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS);
    localparam int BW = $clog2(DBIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DVSR - 2);
    localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICKS - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    logic [CW-1:0]   baud_cnt;
    logic            s_tick;
    logic            pre_tick;

    tx_state_t       state;
    logic [DBIT-1:0] b;
    logic [TW-1:0]   n_ticks;
    logic [BW-1:0]   n_bits;

    logic            fifo_rd;
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_data;

    uart_fifo #(
        .DBIT    (DBIT),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_en),
        .rd     (fifo_rd),
        .w_data (wr_data),
        .r_data (fifo_data),
        .empty  (fifo_empty),
        .full   (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            baud_cnt <= '0;
        else if (s_tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign s_tick   = (baud_cnt == CNT_LAST);
    // One cycle ahead of s_tick, so the done pulse can be registered yet land in the last stop cycle
    assign pre_tick = (baud_cnt == CNT_PRE);

    assign fifo_rd = (state == IDLE) & ~fifo_empty;
    assign tx_busy = (state != IDLE) | ~fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            b            <= '0;
            n_ticks      <= '0;
            n_bits       <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= (state == STOP) & (n_ticks == SB_LAST) & pre_tick;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        b       <= fifo_data;
                        n_ticks <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (n_ticks == OS_LAST) begin
                            n_ticks <= '0;
                            n_bits  <= '0;
                            tx      <= b[0];
                            state   <= DATA;
                        end else begin
                            n_ticks <= n_ticks + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (n_ticks == OS_LAST) begin
                            n_ticks <= '0;
                            b       <= b >> 1;
                            if (n_bits == BIT_LAST) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                n_bits <= n_bits + 1'b1;
                                tx     <= b[1];
                            end
                        end else begin
                            n_ticks <= n_ticks + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (n_ticks == SB_LAST) begin
                            n_ticks <= '0;
                            state   <= IDLE;
                        end else begin
                            n_ticks <= n_ticks + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timeline model checked every cycle, plus an rx model and directed literals.
module tb_uart_tx_buffered;

    localparam int DVSR   = 4;
    localparam int BITLEN = 16 * DVSR;
    localparam int DEPTH  = 4;
    localparam int FRAME_TICKS = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, tx, tx_busy, tx_done_tick;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_buffered #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (DVSR),
        .FIFO_AW (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-timeline model ----------------
    // Ticks land on posedges that are multiples of DVSR counted from reset release.
    logic [7:0] mq[$];
    int         e = 0;
    bit         m_active = 1'b0;
    int         m_t1, m_end;
    logic [7:0] m_byte;

    always @(posedge clk) begin
        bit pop;
        bit acc;
        if (!reset) begin
            mq.delete();
            e = 0;
            m_active = 1'b0;
        end else begin
            e++;
            pop = !m_active && (mq.size() > 0);
            acc = wr_en && ((mq.size() < DEPTH) || pop);
            if (m_active && e == m_end)
                m_active = 1'b0;
            if (pop)
                m_byte = mq.pop_front();
            if (acc)
                mq.push_back(wr_data);
            if (pop) begin
                m_active = 1'b1;
                m_t1  = (e / DVSR + 1) * DVSR;
                m_end = m_t1 + DVSR * (FRAME_TICKS - 1);
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        int idx;
        if (!m_active)
            return 1'b1;
        k   = (e < m_t1) ? 0 : (e - m_t1) / DVSR + 1;
        idx = k / 16;
        if (idx == 0)
            return 1'b0;
        if (idx <= 8)
            return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("tx", tx, exp_tx());
            check("full", full, mq.size() == DEPTH);
            check("tx_busy", tx_busy, m_active || (mq.size() > 0));
            check("tx_done_tick", tx_done_tick, m_active && (e == m_end - 1));
        end
    end

    // ---------------- rx model and done counter ----------------
    logic [7:0] rxq[$];
    logic [9:0] rx_bits = '0;
    logic [9:0] last_frame = '0;
    int         rx_cnt = -1;
    int         n_done = 0;

    always @(negedge clk) begin
        if (!reset) begin
            rx_cnt = -1;
        end else begin
            if (tx_done_tick === 1'b1)
                n_done++;
            if (rx_cnt < 0) begin
                if (tx === 1'b0)
                    rx_cnt = 0;
            end else begin
                rx_cnt++;
                if (rx_cnt % BITLEN == BITLEN / 2)
                    rx_bits[rx_cnt / BITLEN] = tx;
                if (rx_cnt == 9 * BITLEN + BITLEN / 2) begin
                    last_frame = rx_bits;
                    check("rx_framing", {30'd0, rx_bits[9], rx_bits[0]}, 32'd2);
                    rxq.push_back(rx_bits[8:1]);
                    rx_cnt = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (tx_busy !== 1'b0 && i < budget) begin
            step();
            i++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    task automatic wait_fall(input int budget, input string name);
        int i = 0;
        while (tx !== 1'b0 && i < budget) begin
            step();
            i++;
        end
        check(name, tx, 1'b0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (tx_done_tick !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        check(name, tx_done_tick, 1'b1);
    endtask

    task automatic wait_not_full(input int budget, input string name);
        int i = 0;
        while (full !== 1'b0 && i < budget) begin
            step();
            i++;
        end
        check(name, full, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values
        reset = 1'b0;
        repeat (3) step();
        check("rst_tx", tx, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done_tick, 1'b0);
        reset = 1'b1;
        repeat (5) step();

        // 2: single byte A5
        rxq.delete();
        n_done = 0;
        push(8'hA5);
        check("lat_pre", tx, 1'b1);
        step();
        check("lat_fall", tx, 1'b0);
        wait_idle(1000, "a5_idle");
        repeat (3) step();
        check("a5_count", rxq.size(), 1);
        if (rxq.size() > 0)
            check("a5_byte", rxq[0], 8'hA5);
        check("a5_levels", last_frame, 10'b1101001010);
        check("a5_done", n_done, 1);

        // 3 + 4: fill FIFO, drop when full, push in the pop cycle
        rxq.delete();
        n_done = 0;
        for (int i = 1; i <= 5; i++) begin
            push(i[7:0]);
            check("fill_full", full, (i == 5) ? 1'b1 : 1'b0);
        end
        push(8'hFF);
        check("drop_full", full, 1'b1);
        wait_done(1000, "first_done");
        step();
        push(8'h06);
        check("popcycle_full", full, 1'b1);
        wait_idle(6000, "burst_idle");
        repeat (3) step();
        check("burst_count", rxq.size(), 6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            check("burst_byte", rxq[i], i + 1);
        check("burst_done", n_done, 6);

        // 5: reset during data bit 3 of 3C
        rxq.delete();
        n_done = 0;
        push(8'h3C);
        wait_fall(10, "abort_fall");
        repeat (4 * BITLEN + BITLEN / 2) step();
        push(8'h55);
        reset = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_full", full, 1'b0);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_done", tx_done_tick, 1'b0);
        repeat (4) step();
        reset = 1'b1;
        repeat (3) step();
        check("abort_ndone", n_done, 0);
        check("abort_rx", rxq.size(), 0);
        push(8'h81);
        wait_idle(1000, "clean_idle");
        repeat (3) step();
        check("clean_count", rxq.size(), 1);
        if (rxq.size() > 0)
            check("clean_byte", rxq[0], 8'h81);
        check("clean_done", n_done, 1);

        // 6: stream 10 bytes through the wrapping pointers
        rxq.delete();
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            wait_not_full(2000, "stream_space");
            push(8'h10 + i[7:0]);
        end
        wait_idle(8000, "stream_idle");
        repeat (3) step();
        check("stream_count", rxq.size(), 10);
        for (int i = 0; i < 10 && i < rxq.size(); i++)
            check("stream_byte", rxq[i], 8'h10 + i);
        check("stream_done", n_done, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
